ss_adc_ctrl: RTL and testbench
==============================

# ss_adc_ctrl

Conversion sequencer for the single-slope ADC back end. It owns the half-adder ripple counter's `rst`/`en` pins and the analog ramp/sample controls. It runs clear, sample, ramp and capture on each `start`, then latches the count at the comparator trip as the conversion result. It sits between the test/readout logic and one counter instance plus the analog comparator.

## Interface
- `WIDTH`, 8: counter and result width; must match the attached counter.
- `SAMPLE_CYCLES`, 4: cycles the sample switch is held closed (1..255).
- `clk`  in  1: single clock for the block and the attached counter.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: conversion request; single-cycle pulse or level. Sampled only in IDLE.
- `cmp`  in  1: comparator output; goes high when the ramp crosses the input. Asynchronous to `clk`.
- `count`  in  WIDTH: counter `count` output.
- `cnt_ovf`  in  1: counter `overflow` output.
- `cnt_rst`  out  1: drives counter `rst`.
- `cnt_en`  out  1: drives counter `en`.
- `sample_en`  out  1: analog sample switch.
- `ramp_en`  out  1: ramp generator enable.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when `result` updates.
- `result`  out  WIDTH: last conversion value; holds until the next `done`.
- `ovf`  out  1: the last conversion saturated; updates with `done`.

## Operation
- FSM states: IDLE, CLEAR, SAMPLE, RAMP, CAPTURE.
- All outputs are registered Moore outputs, decoded from the state register.
- IDLE: if `start`=1, go to CLEAR.
- CLEAR: lasts 1 cycle. `cnt_rst`=1. Go to SAMPLE.
- SAMPLE: `sample_en`=1 for exactly SAMPLE_CYCLES cycles, using an 8-bit down-counter. Then go to RAMP.
- RAMP: `cnt_en`=1 and `ramp_en`=1.
  - On `cmp_s`=1 (the synchronized comparator), latch `result`=`count` and `ovf`=0, then go to CAPTURE.
  - Else on `cnt_ovf`=1, latch `result`={WIDTH{1'b1}} and `ovf`=1, then go to CAPTURE.
  - If both are seen in the same cycle, `cnt_ovf` wins (saturated result).
- CAPTURE: lasts 1 cycle. `done`=1. Go to IDLE.
- `start` outside IDLE is ignored. There is no queueing.
- `cmp` is ignored outside RAMP. A `cmp` already high on RAMP entry trips in the first evaluated cycle.
- `rst` mid-conversion: immediate return to IDLE. All outputs go to 0, `result`=0, `ovf`=0, and no `done` is issued.

## Timing
- Reset values: `cnt_rst`=0, `cnt_en`=0, `sample_en`=0, `ramp_en`=0, `busy`=0, `done`=0, `result`=0, `ovf`=0.
- From the `start` sample edge, `cnt_rst` is high in cycle 1 and `sample_en` is high in cycles 2..1+SAMPLE_CYCLES.
- RAMP begins at cycle 2+SAMPLE_CYCLES.
- Trip-to-done latency: `done` rises 1 cycle after the RAMP cycle in which the trip is observed.
- Counter relation: the counter increments on every edge while `cnt_en` is high. `count` read in RAMP cycle k (k=0 at entry) equals k.
- Minimum back-to-back period is SAMPLE_CYCLES+4 cycles. This includes a 1-cycle IDLE between conversions.

## Configuration
- `SS_ADC_CTRL_CMP_SYNC_EN` defined:
  - `cmp` passes through a 2-flop synchronizer, so `cmp_s` lags `cmp` by 2 cycles.
  - The captured value is compensated: `result`=`count`-2, saturating at 0.
- Undefined: `cmp_s`=`cmp` directly, for a synchronous comparator model in simulation, with no compensation.
- Overflow handling is identical in both builds.

## Structure
- Shared package `ss_adc_pkg`:
  - state enum (IDLE=0, CLEAR=1, SAMPLE=2, RAMP=3, CAPTURE=4, 3-bit);
  - `CMP_SYNC_STAGES`=2.
- One sub-module, `cmp_sync`: the 2-flop synchronizer with asynchronous active-high reset to 0. It is instantiated only under `SS_ADC_CTRL_CMP_SYNC_EN`.
- The counter is instantiated outside this block. The top level wires `cnt_rst`, `cnt_en`, `count` and `cnt_ovf`.

## Test plan
- Reset then idle: release `rst` with `start`=0 for 20 cycles -> all outputs stay 0 and `busy`=0.
- Nominal conversion, no sync, SAMPLE_CYCLES=4, `cmp` tied to (`count`==37):
  - `cnt_rst` pulses once;
  - `sample_en` is high 4 cycles;
  - `done` pulses with `result`=37 and `ovf`=0.
- Sync build, same stimulus (`cmp` rising when `count`=37) -> `result`=37 and `done` comes 2 cycles later than in the unsynced build.
- Overflow, WIDTH=8, `cmp` held 0 -> after 256 RAMP cycles, `done` pulses with `result`=255 and `ovf`=1.
- Start during `busy`: second `start` at RAMP cycle 5 -> ignored, and exactly one `done` pulse.
- Reset mid-RAMP at `count`=10 -> next cycle all outputs 0, `result`=0, and no `done`. A following `start` converts normally.

Source files
------------

// File: rtl/ss_adc_pkg.sv
// Shared definitions for the single-slope ADC conversion sequencer.
// Holds the FSM state encoding and the comparator synchronizer depth.
package ss_adc_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      SAMPLE  = 3'd2,
      RAMP    = 3'd3,
      CAPTURE = 3'd4
   } adc_state_e;

   localparam int CMP_SYNC_STAGES = 2;

endpackage

// File: rtl/ss_adc_ctrl_cmp_sync.sv
// Multi-flop synchronizer for the asynchronous comparator output.
// Resets to 0 so a stale comparator level cannot trip a fresh conversion.
module cmp_sync
   import ss_adc_pkg::*;
#(
   parameter int STAGES = CMP_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            always_ff @(posedge clk or posedge rst) begin
               if (rst) sync_q[gi] <= 1'b0;
               else     sync_q[gi] <= d_i;
            end
         end else begin : g_next
            always_ff @(posedge clk or posedge rst) begin
               if (rst) sync_q[gi] <= 1'b0;
               else     sync_q[gi] <= sync_q[gi-1];
            end
         end
      end
   endgenerate

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ss_adc_ctrl.sv
// Single-slope ADC sequencer: clear, sample, ramp, capture on each start.
// Define SS_ADC_CTRL_CMP_SYNC_EN to synchronize cmp and compensate the result.
module ss_adc_ctrl
   import ss_adc_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int SAMPLE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cmp,
   input  logic [WIDTH-1:0] count,
   input  logic             cnt_ovf,
   output logic             cnt_rst,
   output logic             cnt_en,
   output logic             sample_en,
   output logic             ramp_en,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             ovf
);

   localparam logic [7:0] SAMPLE_LOAD = 8'(SAMPLE_CYCLES - 1);

   adc_state_e       state_q, state_d;
   logic [7:0]       samp_q, samp_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             ovf_q, ovf_d;
   logic             cnt_rst_q, cnt_en_q, sample_en_q, ramp_en_q, busy_q, done_q;
   logic             cmp_s;
   logic [WIDTH-1:0] cap_val;

`ifdef SS_ADC_CTRL_CMP_SYNC_EN
   localparam logic [WIDTH-1:0] CMP_LAG = WIDTH'(CMP_SYNC_STAGES);

   cmp_sync #(.STAGES(CMP_SYNC_STAGES)) u_cmp_sync (
      .clk (clk),
      .rst (rst),
      .d_i (cmp),
      .q_o (cmp_s)
   );

   // The counter has run on for the synchronizer latency; take it back out.
   assign cap_val = (count >= CMP_LAG) ? (count - CMP_LAG) : '0;
`else
   assign cmp_s   = cmp;
   assign cap_val = count;
`endif

   always_comb begin
      state_d  = state_q;
      samp_d   = samp_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = CLEAR;
         end
         CLEAR: begin
            samp_d  = SAMPLE_LOAD;
            state_d = SAMPLE;
         end
         SAMPLE: begin
            if (samp_q == 8'd0) state_d = RAMP;
            else                samp_d  = samp_q - 8'd1;
         end
         RAMP: begin
            // Overflow takes priority so a wrapped count is never reported.
            if (cnt_ovf) begin
               result_d = '1;
               ovf_d    = 1'b1;
               state_d  = CAPTURE;
            end else if (cmp_s) begin
               result_d = cap_val;
               ovf_d    = 1'b0;
               state_d  = CAPTURE;
            end
         end
         CAPTURE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         samp_q      <= 8'd0;
         result_q    <= '0;
         ovf_q       <= 1'b0;
         cnt_rst_q   <= 1'b0;
         cnt_en_q    <= 1'b0;
         sample_en_q <= 1'b0;
         ramp_en_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         samp_q      <= samp_d;
         result_q    <= result_d;
         ovf_q       <= ovf_d;
         // Output flops decode the next state so they line up with state_q.
         cnt_rst_q   <= (state_d == CLEAR);
         cnt_en_q    <= (state_d == RAMP);
         sample_en_q <= (state_d == SAMPLE);
         ramp_en_q   <= (state_d == RAMP);
         busy_q      <= (state_d != IDLE);
         done_q      <= (state_d == CAPTURE);
      end
   end

   assign cnt_rst   = cnt_rst_q;
   assign cnt_en    = cnt_en_q;
   assign sample_en = sample_en_q;
   assign ramp_en   = ramp_en_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_ss_adc_ctrl.sv
// Self-checking bench for ss_adc_ctrl with a behavioural counter and comparator.
// Expected results and timing come from the conversion rules, not the FSM.
module tb_ss_adc_ctrl;

   localparam int W = 8;
   localparam int S = 4;
`ifdef SS_ADC_CTRL_CMP_SYNC_EN
   localparam int LAG = 2;
`else
   localparam int LAG = 0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] count;
   logic         cnt_ovf;
   logic         cmp;
   logic         cnt_rst, cnt_en, sample_en, ramp_en, busy, done, ovf;
   logic [W-1:0] result;

   logic         cmp_tie_en = 1'b0;
   logic [W-1:0] cmp_target = '0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Comparator trips when the ramp count reaches the input level.
   assign cmp = cmp_tie_en && (count == cmp_target);

   // External ripple counter: sticky overflow flag set on wrap.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         count   <= '0;
         cnt_ovf <= 1'b0;
      end else if (cnt_rst) begin
         count   <= '0;
         cnt_ovf <= 1'b0;
      end else if (cnt_en) begin
         count <= count + 1'b1;
         if (count == {W{1'b1}}) cnt_ovf <= 1'b1;
      end
   end

   ss_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .cmp       (cmp),
      .count     (count),
      .cnt_ovf   (cnt_ovf),
      .cnt_rst   (cnt_rst),
      .cnt_en    (cnt_en),
      .sample_en (sample_en),
      .ramp_en   (ramp_en),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .ovf       (ovf)
   );

   function automatic logic [W+6:0] out_vec();
      return {cnt_rst, cnt_en, sample_en, ramp_en, busy, done, ovf, result};
   endfunction

   // Reference: trip seen LAG cycles after count==t, unless overflow at RAMP cycle 256 comes first.
   task automatic expect_conv(input bit tie, input int t, output int exp_done,
                              output logic [W-1:0] exp_res, output logic exp_ovf);
      int k;
      if (tie && (t + LAG) < 256) begin
         k       = t + LAG;
         exp_res = W'(t);
         exp_ovf = 1'b0;
      end else begin
         k       = 256;
         exp_res = {W{1'b1}};
         exp_ovf = 1'b1;
      end
      exp_done = 2 + S + k + 1;
   endtask

   task automatic run_conv(input string name, input bit tie, input int t, input int extra_start);
      int exp_done, cyc, n_rst, first_rst, n_samp, first_samp, n_done, done_cyc;
      logic [W-1:0] exp_res, got_res;
      logic exp_ovf, got_ovf;
      bit finished;
      expect_conv(tie, t, exp_done, exp_res, exp_ovf);
      cmp_tie_en = tie;
      cmp_target = W'(t);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cyc = 1; n_rst = 0; first_rst = -1; n_samp = 0; first_samp = -1;
      n_done = 0; done_cyc = -1; got_res = '0; got_ovf = 1'b0; finished = 0;
      while (!finished && cyc <= 600) begin
         if (cnt_rst) begin n_rst++; if (first_rst < 0) first_rst = cyc; end
         if (sample_en) begin n_samp++; if (first_samp < 0) first_samp = cyc; end
         if (done) begin n_done++; done_cyc = cyc; got_res = result; got_ovf = ovf; end
         if (n_done > 0 && !busy) finished = 1;
         start = (cyc == extra_start);
         if (!finished) begin
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      n_checks++; if (!finished) begin n_fail++; $display("FAIL %s timeout: cycles=%0d required idle after done", name, cyc); end
      n_checks++; if (n_rst !== 1) begin n_fail++; $display("FAIL %s cnt_rst_pulses: got %0d expected 1", name, n_rst); end
      n_checks++; if (first_rst !== 1) begin n_fail++; $display("FAIL %s cnt_rst_cycle: got %0d expected 1", name, first_rst); end
      n_checks++; if (n_samp !== S) begin n_fail++; $display("FAIL %s sample_cycles: got %0d expected %0d", name, n_samp, S); end
      n_checks++; if (first_samp !== 2) begin n_fail++; $display("FAIL %s sample_start: got %0d expected 2", name, first_samp); end
      n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL %s done_pulses: got %0d expected 1", name, n_done); end
      n_checks++; if (done_cyc !== exp_done) begin n_fail++; $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, exp_done); end
      n_checks++; if (got_res !== exp_res) begin n_fail++; $display("FAIL %s result: got %0d expected %0d", name, got_res, exp_res); end
      n_checks++; if (got_ovf !== exp_ovf) begin n_fail++; $display("FAIL %s ovf: got %0b expected %0b", name, got_ovf, exp_ovf); end
      n_checks++; if (result !== exp_res) begin n_fail++; $display("FAIL %s result_hold: got %0d expected %0d", name, result, exp_res); end
      $display("conv %s: tie=%0b target=%0d done@%0d result=%0d ovf=%0b", name, tie, t, done_cyc, got_res, got_ovf);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (out_vec() !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", out_vec()); end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_checks++;
         if (out_vec() !== '0) begin n_fail++; $display("FAIL idle_outputs cycle %0d: got %h expected 0", i, out_vec()); end
      end
      $display("reset: 20 idle cycles observed");
   endtask

   task automatic test_nominal();
      run_conv("nominal37", 1'b1, 37, -1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 4; i++) run_conv("random", 1'b1, int'($urandom_range(2, 250)), -1);
   endtask

   task automatic test_overflow();
      run_conv("overflow", 1'b0, 0, -1);
   endtask

   task automatic test_start_during_busy();
      run_conv("busy_start", 1'b1, 20, 2 + S + 5);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_checks++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL busy_start_queued cycle %0d: busy=%0b done=%0b expected 0 0", i, busy, done);
         end
      end
   endtask

   task automatic test_back_to_back();
      int exp_done, t, cyc, nd;
      int dc[3];
      logic [W-1:0] exp_res;
      logic [W-1:0] rs[3];
      logic exp_ovf;
      t = int'($urandom_range(2, 20));
      expect_conv(1'b1, t, exp_done, exp_res, exp_ovf);
      cmp_tie_en = 1'b1;
      cmp_target = W'(t);
      @(negedge clk) start = 1'b1;
      cyc = 0; nd = 0;
      while (nd < 3 && cyc < 500) begin
         @(negedge clk);
         cyc++;
         if (done) begin dc[nd] = cyc; rs[nd] = result; nd++; end
      end
      start = 1'b0;
      for (int i = 0; i < 40 && busy; i++) @(negedge clk);
      n_checks++;
      if (nd !== 3) begin
         n_fail++; $display("FAIL b2b_count: got %0d done pulses expected 3", nd);
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rs[i] !== exp_res) begin n_fail++; $display("FAIL b2b_result %0d: got %0d expected %0d", i, rs[i], exp_res); end
         end
         for (int i = 1; i < 3; i++) begin
            n_checks++;
            if (dc[i] - dc[i-1] !== exp_done + 1) begin
               n_fail++; $display("FAIL b2b_period %0d: got %0d expected %0d", i, dc[i] - dc[i-1], exp_done + 1);
            end
         end
         $display("b2b: target=%0d done@%0d,%0d,%0d result=%0d", t, dc[0], dc[1], dc[2], rs[0]);
      end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: busy=%0b expected 0", busy); end
   endtask

   task automatic test_reset_mid();
      cmp_tie_en = 1'b1;
      cmp_target = W'(100);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (2 + S + 10 - 1) @(negedge clk);
      n_checks++;
      if (count !== W'(10)) begin n_fail++; $display("FAIL rst_mid_count: got %0d expected 10", count); end
      rst = 1'b1;
      #1;
      n_checks++;
      if (out_vec() !== '0) begin n_fail++; $display("FAIL rst_mid_outputs: got %h expected 0", out_vec()); end
      @(negedge clk);
      n_checks++;
      if (out_vec() !== '0) begin n_fail++; $display("FAIL rst_mid_next: got %h expected 0", out_vec()); end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_no_done cycle %0d: done=%0b busy=%0b expected 0 0", i, done, busy);
         end
      end
      $display("reset_mid: aborted at count=10");
      run_conv("after_reset", 1'b1, 37, -1);
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_random();
      test_overflow();
      test_start_during_busy();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
